// File: rtl/sr_pulse_encoder_pkg.sv
// Shared definitions for the set/reset pulse encoder.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
//
// Contents:
//   state_e          - encoder FSM state encoding (IDLE=0, PULSE=1, HOLD=2)
//   CNT_W_DEFAULT    - default counter width
//   cnt_preload()    - converts a duration in cycles into a down-counter preload
//   cnt_fits()       - true when a duration is representable in a counter width
package sr_pulse_encoder_pkg;

    // Encodings are fixed so that the flop-side bench can decode the
    // state from the same definitions.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    localparam int CNT_W_DEFAULT = 8;

    // A down-counter that is loaded with N-1 and leaves its state on the
    // edge where it reads zero spans exactly N cycles. A zero-length
    // duration never gets loaded, so it clamps to 0 rather than wrapping.
    function automatic int cnt_preload(input int cycles);
        return (cycles > 0) ? cycles - 1 : 0;
    endfunction

    // True when a duration fits into a counter of the given width.
    function automatic bit cnt_fits(input int cycles, input int width);
        return (cycles >= 0) && (cycles < (1 << width));
    endfunction

endpackage : sr_pulse_encoder_pkg

// File: rtl/sr_dcount.sv
// Loadable down-counter with a zero flag, shared by the PULSE and HOLD phases.
// Latency: load or decrement takes effect on the next rising edge; zero_o
// follows the counter register directly. Backpressure: none.
//
// Ports:
//   clk_i       - clock
//   rst_i       - synchronous active-high reset (clears the count)
//   load_i      - load load_val_i on the next edge (takes priority over dec_i)
//   load_val_i  - value to load
//   dec_i       - decrement on the next edge; saturates at zero
//   zero_o      - count is zero
module sr_dcount #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            // Saturating so a stray decrement at zero can never wrap
            // into a huge count and stall the owning FSM.
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule : sr_dcount

// File: rtl/sr_pulse_encoder.sv
// Turns a handshaked level request into set/reset pulses for an SR flop,
// tracking the flop state and checking its Q feedback.
// Latency: pulse rises one edge after accept, lasts PULSE_W cycles, then
// HOLDOFF idle cycles. Backpressure: lvl_ready_o low from pulse start until
// the hold-off ends; no-op requests (level already matches) are accepted
// every cycle.
//
// Ports:
//   clk_i        - clock, all state on the rising edge
//   rst_i        - synchronous active-high reset (flop is reset alongside)
//   lvl_i        - requested flop level
//   lvl_valid_i  - lvl_i valid this cycle
//   lvl_ready_o  - request accepted when lvl_valid_i && lvl_ready_o
//   sr_set_o     - to flop set
//   sr_rst_o     - to flop rst
//   q_fb_i       - flop Q feedback
//   q_model_o    - encoder's model of the flop state
//   mismatch_o   - sticky: q_fb_i disagreed with q_model_o while checked
module sr_pulse_encoder
    import sr_pulse_encoder_pkg::*;
#(
    parameter int PULSE_W = 1,
    parameter int HOLDOFF = 4,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic lvl_i,
    input  logic lvl_valid_i,
    output logic lvl_ready_o,
    output logic sr_set_o,
    output logic sr_rst_o,
    input  logic q_fb_i,
    output logic q_model_o,
    output logic mismatch_o
);

    // Counter preloads: a phase of N cycles is loaded with N-1 and ends on
    // the edge where the counter reads zero.
    localparam logic [CNT_W-1:0] PW_PRE = CNT_W'(cnt_preload(PULSE_W));
    localparam logic [CNT_W-1:0] HO_PRE = CNT_W'(cnt_preload(HOLDOFF));

    state_e state_q;
    logic   sr_set_q;
    logic   sr_rst_q;
    logic   q_model_q;
    logic   mismatch_q;
    logic   lvl_ready_q;

    logic             accept;
    logic             need_pulse;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_dec;
    logic             cnt_zero;

    assign accept     = lvl_valid_i && lvl_ready_q;
    assign need_pulse = accept && (lvl_i != q_model_q);

    // Counter control. The single counter times both the pulse and the
    // hold-off: it is reloaded on the PULSE->HOLD edge.
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (need_pulse) begin
                    cnt_load = 1'b1;
                    cnt_val  = PW_PRE;
                end
            end
            ST_PULSE: begin
                if (cnt_zero) begin
                    if (HOLDOFF != 0) begin
                        cnt_load = 1'b1;
                        cnt_val  = HO_PRE;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_HOLD: begin
                cnt_dec = !cnt_zero;
            end
            default: begin
                cnt_load = 1'b0;
            end
        endcase
    end

    sr_dcount #(
        .W (CNT_W)
    ) u_dcount (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // FSM, flop model and feedback checker. Every output is a register so
    // set and reset can only ever change together on one edge, and both are
    // cleared by reset in the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            sr_set_q    <= 1'b0;
            sr_rst_q    <= 1'b0;
            q_model_q   <= 1'b0;
            mismatch_q  <= 1'b0;
            lvl_ready_q <= 1'b1;
        end else begin
            // The flop is still settling while a pulse is applied, so the
            // feedback is only trusted in IDLE and HOLD.
            if ((state_q != ST_PULSE) && (q_fb_i != q_model_q)) begin
                mismatch_q <= 1'b1;
            end

            unique case (state_q)
                ST_IDLE: begin
                    // A request matching the model is accepted and dropped;
                    // ready stays high so no-op accepts can stream.
                    if (need_pulse) begin
                        state_q     <= ST_PULSE;
                        sr_set_q    <= lvl_i;
                        sr_rst_q    <= !lvl_i;
                        lvl_ready_q <= 1'b0;
                    end
                end
                ST_PULSE: begin
                    if (cnt_zero) begin
                        sr_set_q  <= 1'b0;
                        sr_rst_q  <= 1'b0;
                        // A pulse is only issued on a differing level, so
                        // its completion always flips the modelled state.
                        q_model_q <= !q_model_q;
                        if (HOLDOFF == 0) begin
                            state_q     <= ST_IDLE;
                            lvl_ready_q <= 1'b1;
                        end else begin
                            state_q <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt_zero) begin
                        state_q     <= ST_IDLE;
                        lvl_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    sr_set_q    <= 1'b0;
                    sr_rst_q    <= 1'b0;
                    lvl_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign lvl_ready_o = lvl_ready_q;
    assign sr_set_o    = sr_set_q;
    assign sr_rst_o    = sr_rst_q;
    assign q_model_o   = q_model_q;
    assign mismatch_o  = mismatch_q;

endmodule : sr_pulse_encoder
